// File: rtl/ic_check_pkg.sv
// Shared definitions for the bvslt/bvurem witness checker: FSM states and default width.
package ic_check_pkg;

   localparam int unsigned IC_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DIV  = 2'd1,
      ST_DONE = 2'd2
   } ic_state_e;

endpackage

// File: rtl/urem_step.sv
// One restoring-division step: shift the next dividend bit into the partial remainder
// and subtract the divisor when it fits.
module urem_step #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] i_r,
   input  logic         i_bit,
   input  logic [W-1:0] i_s,
   output logic [W-1:0] o_r
);

   logic [W:0]   w_trial;
   logic [W-1:0] w_diff;
   logic         w_ge;

   assign w_trial = {i_r, i_bit};
   assign w_ge    = (w_trial >= {1'b0, i_s});
   // Difference is below 2^W whenever the subtraction is taken, so W bits suffice.
   assign w_diff  = w_trial[W-1:0] - i_s;
   assign o_r     = w_ge ? w_diff : w_trial[W-1:0];

endmodule

// File: rtl/ic_bvslt_bvurem_checker.sv
// Bit-serial witness checker: computes x urem s with a restoring divider and reports
// whether the remainder is signed-less-than t, over valid/ready handshakes.
module ic_bvslt_bvurem_checker
   import ic_check_pkg::*;
#(
   parameter int unsigned W = IC_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_x,
   input  logic [W-1:0] in_s,
   input  logic [W-1:0] in_t,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_rem,
   output logic         out_holds
);

   localparam int unsigned CW = $clog2(W);

   ic_state_e    r_state;
   logic [W-1:0] r_x;
   logic [W-1:0] r_s;
   logic [W-1:0] r_t;
   logic [W-1:0] r_rem;
   logic [CW-1:0] r_cnt;
   logic [W-1:0] r_out_rem;
   logic         r_out_holds;

   logic [W-1:0] w_step_r;
   logic         w_holds_zero;
   logic         w_holds_div;

   urem_step #(
      .W (W)
   ) u_urem_step (
      .i_r   (r_rem),
      .i_bit (r_x[W-1]),
      .i_s   (r_s),
      .o_r   (w_step_r)
   );

   assign w_holds_zero = ($signed(in_x) < $signed(in_t));
   assign w_holds_div  = ($signed(w_step_r) < $signed(r_t));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_x         <= '0;
         r_s         <= '0;
         r_t         <= '0;
         r_rem       <= '0;
         r_cnt       <= '0;
         r_out_rem   <= '0;
         r_out_holds <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_x   <= in_x;
                  r_s   <= in_s;
                  r_t   <= in_t;
                  r_rem <= '0;
                  r_cnt <= CW'(W - 1);
                  // x urem 0 is defined as x, so skip the divider entirely.
                  if (in_s == '0) begin
                     r_state     <= ST_DONE;
                     r_out_rem   <= in_x;
                     r_out_holds <= w_holds_zero;
                  end else begin
                     r_state <= ST_DIV;
                  end
               end
            end
            ST_DIV: begin
               r_rem <= w_step_r;
               r_x   <= {r_x[W-2:0], 1'b0};
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == '0) begin
                  r_state     <= ST_DONE;
                  r_out_rem   <= w_step_r;
                  r_out_holds <= w_holds_div;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == ST_IDLE);
   assign out_valid = (r_state == ST_DONE);
   assign out_rem   = r_out_rem;
   assign out_holds = r_out_holds;

endmodule

// File: tb/tb_ic_bvslt_bvurem_checker.sv
// Directed and exhaustive checks of the bvslt/bvurem witness checker at W=4.
module tb_ic_bvslt_bvurem_checker;

   localparam int unsigned W = 4;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_x;
   logic [W-1:0] in_s;
   logic [W-1:0] in_t;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_rem;
   logic         out_holds;

   int n_checks = 0;
   int n_fail   = 0;

   ic_bvslt_bvurem_checker #(
      .W (W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_x      (in_x),
      .in_s      (in_s),
      .in_t      (in_t),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_rem   (out_rem),
      .out_holds (out_holds)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Presents one triple for a single cycle; returns at #1 after the accepting edge (cycle 1).
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] s, input logic [W-1:0] t);
      check_eq("in_ready_before_send", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_x     = x;
      in_s     = s;
      in_t     = t;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // Waits for out_valid, returns the cycle index (relative to accept at cycle 0) it appeared.
   task automatic wait_valid(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 64) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic drain;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq("valid_after_drain", {31'd0, out_valid}, 32'd0);
      check_eq("ready_after_drain", {31'd0, in_ready}, 32'd1);
   endtask

   task automatic directed(input string tag, input logic [W-1:0] x, input logic [W-1:0] s,
                           input logic [W-1:0] t, input int exp_lat, input logic [W-1:0] exp_rem,
                           input logic exp_holds);
      int cyc;
      send(x, s, t);
      wait_valid(cyc);
      check_eq({tag, "_latency"}, cyc, exp_lat);
      check_eq({tag, "_rem"}, {28'd0, out_rem}, {28'd0, exp_rem});
      check_eq({tag, "_holds"}, {31'd0, out_holds}, {31'd0, exp_holds});
      drain();
   endtask

   initial begin
      int cyc;
      int n;
      bit done;
      logic [W-1:0] e_rem;
      logic         e_holds;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_x      = '0;
      in_s      = '0;
      in_t      = '0;
      out_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_rem", {28'd0, out_rem}, 32'd0);
      check_eq("rst_out_holds", {31'd0, out_holds}, 32'd0);

      directed("x13s5t4", 4'd13, 4'd5, 4'd4, 5, 4'd3, 1'b1);
      directed("x7s0t7", 4'd7, 4'd0, 4'd7, 1, 4'd7, 1'b0);
      directed("x9s4tm8", 4'd9, 4'd4, 4'b1000, 5, 4'd1, 1'b0);
      directed("x15s0t0", 4'd15, 4'd0, 4'd0, 1, 4'd15, 1'b1);

      // Backpressure: result held for five cycles while a second triple is offered.
      send(4'd13, 4'd5, 4'd4);
      wait_valid(cyc);
      check_eq("bp_latency", cyc, 5);
      in_valid = 1'b1;
      in_x     = 4'd2;
      in_s     = 4'd3;
      in_t     = 4'd0;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp_valid", {31'd0, out_valid}, 32'd1);
         check_eq("bp_rem", {28'd0, out_rem}, 32'd3);
         check_eq("bp_holds", {31'd0, out_holds}, 32'd1);
         check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      drain();
      for (int i = 0; i < 4; i++) begin
         check_eq("bp_no_second", {31'd0, out_valid}, 32'd0);
         @(posedge clk);
         #1;
      end

      // Reset during the divide aborts the transaction.
      send(4'd13, 4'd5, 4'd4);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("abort_valid", {31'd0, out_valid}, 32'd0);
      check_eq("abort_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         check_eq("abort_no_stale", {31'd0, out_valid}, 32'd0);
      end
      directed("x10s3t2", 4'd10, 4'd3, 4'd2, 5, 4'd1, 1'b1);

      // Exhaustive sweep with random output stalls (out_ready may lead out_valid).
      for (int ix = 0; ix < 16; ix++) begin
         for (int is = 0; is < 16; is++) begin
            for (int it = 0; it < 16; it++) begin
               e_rem   = (is == 0) ? 4'(ix) : 4'(ix % is);
               e_holds = ($signed(e_rem) < $signed(4'(it)));
               send(4'(ix), 4'(is), 4'(it));
               n    = 0;
               done = 1'b0;
               while (!done && n < 100) begin
                  out_ready = 1'($urandom_range(0, 1));
                  if (out_valid) begin
                     check_eq("sweep_rem", {28'd0, out_rem}, {28'd0, e_rem});
                     check_eq("sweep_holds", {31'd0, out_holds}, {31'd0, e_holds});
                     if (out_ready) done = 1'b1;
                  end
                  @(posedge clk);
                  #1;
                  n++;
               end
               out_ready = 1'b0;
               check_eq("sweep_transfer", {31'd0, done}, 32'd1);
               if (!done) begin
                  $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
                  $fatal(1, "sweep stalled");
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
